// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LWSTALL = 2'd1,
    FLUSH   = 2'd2,
    FREEZE  = 2'd3
  } state_e;

  // State to resume once a data-memory freeze ends.
  typedef enum logic {
    RET_RUN   = 1'b0,
    RET_FLUSH = 1'b1
  } ret_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int BR_PENALTY_MIN = 1;
  localparam int BR_PENALTY_MAX = 7;

  // Initial flush_left value; out-of-range penalties are pulled into the legal range.
  function automatic logic [2:0] flush_init(input int penalty);
    int p;
    if (penalty < BR_PENALTY_MIN) begin
      p = BR_PENALTY_MIN;
    end else if (penalty > BR_PENALTY_MAX) begin
      p = BR_PENALTY_MAX;
    end else begin
      p = penalty;
    end
    return 3'(p - 1);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       lu
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (ex_rt == id_rs);
  assign w_rt_match = id_uses_rt & (ex_rt == id_rt);
  assign lu         = ex_memread & (ex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, multi-cycle branch flushes,
// data-memory freeze, and saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush_lwstall,
  output logic             id_ex_flush_branch,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] FLUSH_INIT = flush_init(BR_PENALTY);

  state_e           r_state;
  state_e           w_next_state;
  state_e           w_eff_state;
  logic [2:0]       r_flush_left;
  logic [2:0]       w_next_flush_left;
  ret_e             r_ret_state;
  ret_e             w_next_ret_state;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_lu;
  logic             w_branch_accept;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu         (w_lu)
  );

  // FREEZE behaves like the state it interrupted; every rule below keys on this view.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == FREEZE) begin
      if (r_ret_state == RET_FLUSH) begin
        w_eff_state = FLUSH;
      end else begin
        w_eff_state = RUN;
      end
    end else begin
      w_eff_state = r_state;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_flush_left <= 3'd0;
      r_ret_state  <= RET_RUN;
    end else begin
      r_state      <= w_next_state;
      r_flush_left <= w_next_flush_left;
      r_ret_state  <= w_next_ret_state;
    end
  end

  // Next-state logic; mem_busy outranks branch, which outranks load-use.
  always_comb begin
    w_next_state      = r_state;
    w_next_flush_left = r_flush_left;
    w_next_ret_state  = r_ret_state;
    if (mem_busy) begin
      w_next_state = FREEZE;
      if (r_state == FREEZE) begin
        w_next_ret_state = r_ret_state;
      end else if (r_state == FLUSH) begin
        w_next_ret_state = RET_FLUSH;
      end else begin
        w_next_ret_state = RET_RUN;
      end
    end else begin
      case (w_eff_state)
        RUN, LWSTALL: begin
          if (mem_branch_taken) begin
            w_next_flush_left = FLUSH_INIT;
            if (FLUSH_INIT != 3'd0) begin
              w_next_state = FLUSH;
            end else begin
              w_next_state = RUN;
            end
          end else if (w_lu && (w_eff_state == RUN)) begin
            w_next_state = LWSTALL;
          end else begin
            w_next_state = RUN;
          end
        end
        FLUSH: begin
          if (r_flush_left <= 3'd1) begin
            w_next_flush_left = 3'd0;
            w_next_state      = RUN;
          end else begin
            w_next_flush_left = r_flush_left - 3'd1;
            w_next_state      = FLUSH;
          end
        end
        default: begin
          w_next_flush_left = 3'd0;
          w_next_state      = RUN;
        end
      endcase
    end
  end

  // Mealy outputs so a hazard is suppressed in the cycle it is detected.
  always_comb begin
    pc_write            = 1'b1;
    if_id_write         = 1'b1;
    id_ex_write         = 1'b1;
    ex_mem_write        = 1'b1;
    if_id_flush         = 1'b0;
    id_ex_flush_lwstall = 1'b0;
    id_ex_flush_branch  = 1'b0;
    ex_mem_flush        = 1'b0;
    w_branch_accept     = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else begin
      case (w_eff_state)
        RUN, LWSTALL: begin
          if (mem_branch_taken) begin
            if_id_flush        = 1'b1;
            id_ex_flush_branch = 1'b1;
            ex_mem_flush       = 1'b1;
            w_branch_accept    = 1'b1;
          end else if (w_lu && (w_eff_state == RUN)) begin
            pc_write            = 1'b0;
            if_id_write         = 1'b0;
            id_ex_flush_lwstall = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush        = 1'b1;
          id_ex_flush_branch = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_branch_accept && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int P    = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread, mem_branch_taken, mem_busy;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_flush_lwstall, id_ex_flush_branch, ex_mem_flush;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Model: flush cycles still owed, whether a load-use bubble sits in EX, event counts.
  int m_flush_rem = 0;
  bit m_bubble    = 1'b0;
  int m_stall     = 0;
  int m_flush     = 0;
  bit m_cnt_known = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BR_PENALTY(P), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_rs               (id_rs),
    .id_rt               (id_rt),
    .id_uses_rt          (id_uses_rt),
    .ex_memread          (ex_memread),
    .ex_rt               (ex_rt),
    .mem_branch_taken    (mem_branch_taken),
    .mem_busy            (mem_busy),
    .pc_write            (pc_write),
    .if_id_write         (if_id_write),
    .id_ex_write         (id_ex_write),
    .ex_mem_write        (ex_mem_write),
    .if_id_flush         (if_id_flush),
    .id_ex_flush_lwstall (id_ex_flush_lwstall),
    .id_ex_flush_branch  (id_ex_flush_branch),
    .ex_mem_flush        (ex_mem_flush),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, settle, compare against the model, then advance the model.
  task automatic cycle(input logic r, input int rs, input int rt, input logic ur,
                       input logic mr, input int ert, input logic br, input logic bz);
    logic [7:0] exp_ctrl;
    logic [7:0] obs_ctrl;
    bit lu;
    @(negedge clk);
    rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ur;
    ex_memread = mr; ex_rt = 5'(ert); mem_branch_taken = br; mem_busy = bz;
    #1;
    lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    // bit order: pc, if_id, id_ex, ex_mem writes; if_id, lwstall, branch, ex_mem flushes
    if (r)                       exp_ctrl = 8'b0000_0000;
    else if (bz)                 exp_ctrl = 8'b0000_0000;
    else if (m_flush_rem > 0)    exp_ctrl = 8'b1111_1010;
    else if (br)                 exp_ctrl = 8'b1111_1011;
    else if (lu && !m_bubble)    exp_ctrl = 8'b0011_0100;
    else                         exp_ctrl = 8'b1111_0000;
    obs_ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush_lwstall, id_ex_flush_branch, ex_mem_flush};
    chk("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
    if (m_cnt_known) begin
      chk("stall_count", 32'(stall_count), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
    end
    if (r) begin
      m_flush_rem = 0; m_bubble = 1'b0; m_stall = 0; m_flush = 0; m_cnt_known = 1'b1;
    end else if (bz) begin
      m_bubble = 1'b0;
      if (m_stall < CMAX) m_stall++;
    end else if (m_flush_rem > 0) begin
      m_flush_rem--; m_bubble = 1'b0;
    end else if (br) begin
      m_flush_rem = P - 1; m_bubble = 1'b0;
      if (m_flush < CMAX) m_flush++;
    end else if (lu && !m_bubble) begin
      m_bubble = 1'b1;
      if (m_stall < CMAX) m_stall++;
    end else begin
      m_bubble = 1'b0;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle();
    // load-use on rs, held for a second cycle to see the mask
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    idle();
    // load-use on rt
    cycle(1'b0, 4, 9, 1'b1, 1'b1, 9, 1'b0, 1'b0);
    idle();
    // no false hazards: $zero destination, rt unused
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, 4, 9, 1'b0, 1'b1, 9, 1'b0, 1'b0);
    cycle(1'b0, 9, 9, 1'b1, 1'b0, 9, 1'b0, 1'b0);
    // taken branch pulse
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(); idle(); idle(); idle();
    // freeze during the flush sequence
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(); idle(); idle();
    // branch held while memory busy, serviced on the exit cycle
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(); idle(); idle();
    // load-use stall interrupted by busy; exit re-evaluates the hazard
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b1);
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    cycle(1'b0, 8, 3, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    idle();
    // reset in the middle of a flush
    cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(); idle();
    // counter saturation
    for (int i = 0; i < 20; i++) cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      idle(); idle();
    end
    idle();
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 2),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 15));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
